// File: rtl/uart_loader_if.sv
// Loader bus bundle: UART byte handshakes plus the single-word write port.
// The master side is the loader; the slave side is the UART/memory fabric.
interface uart_loader_if;
  logic        rx_complete;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_complete;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    input  rx_complete, rx_data, tx_complete, mem_ready,
    output tx_valid, tx_data, mem_valid, mem_addr, mem_wdata
  );

  modport slave (
    output rx_complete, rx_data, tx_complete, mem_ready,
    input  tx_valid, tx_data, mem_valid, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_loader.sv
// Serial boot loader: parses load/run packets into single-word writes and ACK/NAK replies.
// Optional mid-packet idle abort is built when UART_LOADER_TIMEOUT_EN is defined.
module uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic          clock,
  input  logic          reset_n,
  uart_loader_if.master bus,
  output logic          run_pulse,
  output logic [31:0]   run_addr,
  output logic          busy,
  output logic          err_csum,
  output logic          err_overrun,
  output logic          err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  localparam logic [7:0] SYNC_LOAD = 8'hB0;
  localparam logic [7:0] SYNC_RUN  = 8'hB1;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  logic [2:0]  state;
  logic        is_run;
  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;
  logic [31:0] wr_addr;
  logic [15:0] words_left;
  logic [7:0]  sum;
  logic        mem_valid_q;
  mem_req_t    req_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;

  logic        rx;
  logic [7:0]  rx_byte;
  logic [31:0] word;
  logic [15:0] count_w;
  logic [7:0]  sum_n;
  logic        slot_free;
  logic        sync_hit;
  logic        tmo_hit;

  assign rx        = bus.rx_complete;
  assign rx_byte   = bus.rx_data;
  // One shift register serves address, count and data: fields arrive LSB first.
  assign word      = {rx_byte, shift_q};
  assign count_w   = {rx_byte, shift_q[23:16]};
  assign sum_n     = sum + rx_byte;
  assign slot_free = !mem_valid_q || bus.mem_ready;
  assign sync_hit  = (state == S_IDLE) && rx && (rx_byte == SYNC_LOAD || rx_byte == SYNC_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      is_run      <= 1'b0;
      byte_cnt    <= 2'd0;
      shift_q     <= '0;
      wr_addr     <= '0;
      words_left  <= '0;
      sum         <= '0;
      mem_valid_q <= 1'b0;
      req_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      run_addr    <= '0;
      err_csum    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (mem_valid_q && bus.mem_ready) mem_valid_q <= 1'b0;
      if (rx && (state == S_ADDR || state == S_COUNT || state == S_DATA)) begin
        shift_q  <= {rx_byte, shift_q[23:8]};
        sum      <= sum_n;
        byte_cnt <= byte_cnt + 2'd1;
      end
      case (state)
        S_IDLE: if (sync_hit) begin
          is_run      <= rx_byte[0];
          sum         <= '0;
          byte_cnt    <= 2'd0;
          err_csum    <= 1'b0;
          err_overrun <= 1'b0;
          state       <= S_ADDR;
        end
        S_ADDR: if (rx && byte_cnt == 2'd3) begin
          wr_addr <= is_run ? word : {word[31:2], 2'b00};
          state   <= is_run ? S_CSUM : S_COUNT;
        end
        S_COUNT: if (rx && byte_cnt == 2'd1) begin
          byte_cnt   <= 2'd0;
          words_left <= count_w;
          state      <= (count_w == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (rx && byte_cnt == 2'd3) begin
          // An acceptance this cycle frees the slot for the word completing now.
          if (slot_free) begin
            mem_valid_q <= 1'b1;
            req_q       <= '{addr: wr_addr, wdata: word};
            wr_addr     <= wr_addr + 32'd4;
          end else begin
            err_overrun <= 1'b1;
          end
          words_left <= words_left - 16'd1;
          if (words_left == 16'd1) state <= S_CSUM;
        end
        S_CSUM: if (rx) begin
          err_csum <= (sum_n != 8'd0);
          if (is_run && sum_n == 8'd0) run_addr <= wr_addr;
          state <= S_DRAIN;
        end
        S_DRAIN: if (!mem_valid_q) begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= (err_csum || err_overrun || err_timeout) ? NAK : ACK;
          state      <= S_RESP;
        end
        S_RESP: if (bus.tx_complete) begin
          tx_valid_q <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (tmo_hit) begin
        mem_valid_q <= 1'b0;
        tx_valid_q  <= 1'b1;
        tx_data_q   <= NAK;
        state       <= S_RESP;
      end
    end
  end

`ifdef UART_LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        err_tmo_q;
  logic        in_pkt;

  assign in_pkt  = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA) || (state == S_CSUM);
  assign tmo_hit = in_pkt && !rx && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt   <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      if (sync_hit) err_tmo_q <= 1'b0;
      if (tmo_hit) err_tmo_q <= 1'b1;
      if (!in_pkt || rx || tmo_hit) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign err_timeout = err_tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign run_pulse     = (state == S_RESP) && bus.tx_complete && is_run && (tx_data_q == ACK);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: packets are built from byte lists, a queue model
// predicts writes, replies and run strobes, and one negedge process checks the DUT.
module tb_uart_loader;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run_pulse, busy, err_csum, err_overrun, err_timeout;
  logic [31:0] run_addr;

  uart_loader_if bus();

  uart_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .run_pulse(run_pulse), .run_addr(run_addr), .busy(busy),
    .err_csum(err_csum), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  pkt[$];
  logic [31:0] words[$];
  logic [31:0] exp_addr[$], exp_data[$], exp_runa[$];
  logic [7:0]  exp_resp[$];
  bit          exp_runv[$];

  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic [7:0]  last_resp = '0;
  int          run_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Model: a packet's bytes determine its writes, reply byte and run strobe.
  task automatic build(input bit run, input logic [31:0] a, input logic [7:0] cadj);
    logic [7:0]  s;
    logic [31:0] wa;
    pkt.delete();
    pkt.push_back(run ? 8'hB1 : 8'hB0);
    for (int i = 0; i < 4; i++) pkt.push_back(a[8*i +: 8]);
    if (!run) begin
      pkt.push_back(8'(words.size()));
      pkt.push_back(8'(words.size() >> 8));
      for (int w = 0; w < words.size(); w++)
        for (int i = 0; i < 4; i++) pkt.push_back(words[w][8*i +: 8]);
    end
    s = 8'h00;
    for (int i = 1; i < pkt.size(); i++) s = s + pkt[i];
    pkt.push_back(8'h00 - s + cadj);
    s = 8'h00;
    for (int i = 1; i < pkt.size(); i++) s = s + pkt[i];
    exp_resp.push_back((s == 8'h00) ? ACK : NAK);
    exp_runv.push_back(run && (s == 8'h00));
    exp_runa.push_back(a);
    if (!run) begin
      wa = {a[31:2], 2'b00};
      for (int w = 0; w < words.size(); w++) begin
        exp_addr.push_back(wa);
        exp_data.push_back(words[w]);
        wa = wa + 32'd4;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    bus.rx_complete = 1'b1;
    bus.rx_data     = b;
    @(posedge clock); #1;
    bus.rx_complete = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gap, input int chk_idx);
    for (int i = first; i <= last; i++) begin
      send_byte(pkt[i]);
      if (i == chk_idx - 1) chk("mem_valid_before_word", 32'(bus.mem_valid), 32'd0);
      if (i == chk_idx)     chk("mem_valid_after_word", 32'(bus.mem_valid), 32'd1);
      if (i != last) repeat (gap) @(posedge clock);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || bus.tx_valid) && n < 1000) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 1000) miss({name, "_done_timeout"}, 32'(busy));
    else chk({name, "_resp_consumed"}, 32'(exp_resp.size()), 32'd0);
  endtask

  initial begin
    bus.tx_complete = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.tx_valid) begin
        repeat (2) @(posedge clock);
        #1 bus.tx_complete = 1'b1;
        @(posedge clock);
        #1 bus.tx_complete = 1'b0;
      end
    end
  end

  logic        prev_mv = 1'b0, prev_acc = 1'b0, prev_txdone = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.mem_valid) chk("addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
      if (prev_mv && !prev_acc && bus.mem_valid) begin
        chk("addr_stable", bus.mem_addr, prev_addr);
        chk("data_stable", bus.mem_wdata, prev_data);
      end
      if (bus.mem_valid && bus.mem_ready) begin
        if (exp_addr.size() == 0) miss("unexpected_write", bus.mem_addr);
        else begin
          chk("wr_addr", bus.mem_addr, exp_addr.pop_front());
          chk("wr_data", bus.mem_wdata, exp_data.pop_front());
        end
        last_waddr = bus.mem_addr;
        last_wdata = bus.mem_wdata;
      end
      if (prev_txdone) chk("tx_valid_fall", 32'(bus.tx_valid), 32'd0);
      if (bus.tx_valid && bus.tx_complete) begin
        last_resp = bus.tx_data;
        if (exp_resp.size() == 0) miss("unexpected_resp", 32'(bus.tx_data));
        else begin
          chk("resp_byte", 32'(bus.tx_data), 32'(exp_resp.pop_front()));
          chk("run_pulse", 32'(run_pulse), 32'(exp_runv[0]));
          if (exp_runv[0]) chk("run_addr", run_addr, exp_runa[0]);
          void'(exp_runv.pop_front());
          void'(exp_runa.pop_front());
        end
      end else if (run_pulse) miss("run_pulse_spurious", 32'(run_pulse));
      if (run_pulse) run_pulses++;
    end
    prev_mv     = reset_n && bus.mem_valid;
    prev_acc    = bus.mem_valid && bus.mem_ready;
    prev_addr   = bus.mem_addr;
    prev_data   = bus.mem_wdata;
    prev_txdone = reset_n && bus.tx_valid && bus.tx_complete;
  end

  initial begin
    logic [7:0] cs;
    reset_n         = 1'b0;
    bus.rx_complete = 1'b0;
    bus.rx_data     = 8'h00;
    bus.mem_ready   = 1'b1;
    #15;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_run", {30'd0, run_pulse, busy}, 32'd0);
    chk("rst_run_addr", run_addr, 32'd0);
    chk("rst_errs", {29'd0, err_csum, err_overrun, err_timeout}, 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Good load packet, ready always high.
    words.delete();
    words.push_back(32'h11223344);
    words.push_back(32'hAABBCCDD);
    build(1'b0, 32'h00001000, 8'h00);
    cs = pkt[pkt.size()-1];
    chk("t1_csum_literal", 32'(cs), 32'h36);
    send_range(0, pkt.size()-1, 3, 10);
    wait_done("t1");
    chk("t1_last_waddr", last_waddr, 32'h00001004);
    chk("t1_last_wdata", last_wdata, 32'hAABBCCDD);
    chk("t1_resp_literal", 32'(last_resp), 32'h06);
    chk("t1_err_csum", 32'(err_csum), 32'd0);

    // Same packet, checksum off by one.
    build(1'b0, 32'h00001000, 8'h01);
    cs = pkt[pkt.size()-1];
    chk("t2_csum_literal", 32'(cs), 32'h37);
    send_range(0, pkt.size()-1, 3, 10);
    wait_done("t2");
    chk("t2_err_csum", 32'(err_csum), 32'd1);
    chk("t2_resp_literal", 32'(last_resp), 32'h15);

    // Run packet: reply two cycles after the csum byte, run strobe with tx_complete.
    build(1'b1, 32'h00000400, 8'h00);
    cs = pkt[pkt.size()-1];
    chk("t3_csum_literal", 32'(cs), 32'hFC);
    send_range(0, pkt.size()-1, 2, -1);
    chk("t3_tx_not_yet", 32'(bus.tx_valid), 32'd0);
    @(posedge clock); #1;
    chk("t3_tx_rise", 32'(bus.tx_valid), 32'd1);
    wait_done("t3");
    chk("t3_run_addr", run_addr, 32'h00000400);
    chk("t3_run_pulses", 32'(run_pulses), 32'd1);
    chk("t3_err_csum_cleared", 32'(err_csum), 32'd0);

    // Overrun: ready low across both word completions, second word dropped.
    bus.mem_ready = 1'b0;
    words.delete();
    words.push_back(32'hCAFEF00D);
    words.push_back(32'h12345678);
    build(1'b0, 32'h00002002, 8'h00);
    void'(exp_addr.pop_back());
    void'(exp_data.pop_back());
    void'(exp_resp.pop_back());
    exp_resp.push_back(NAK);
    send_range(0, pkt.size()-1, 3, 10);
    repeat (10) @(posedge clock); #1;
    chk("t4_no_resp_while_pending", 32'(bus.tx_valid), 32'd0);
    chk("t4_pending", 32'(bus.mem_valid), 32'd1);
    chk("t4_pending_addr", bus.mem_addr, 32'h00002000);
    chk("t4_err_overrun", 32'(err_overrun), 32'd1);
    bus.mem_ready = 1'b1;
    wait_done("t4");
    chk("t4_resp_literal", 32'(last_resp), 32'h15);
    chk("t3_run_addr_held", run_addr, 32'h00000400);

    // Garbage bytes, then an empty load.
    send_byte(8'h55);
    repeat (2) @(posedge clock);
    send_byte(8'h00);
    chk("t5_garbage_idle", 32'(busy), 32'd0);
    words.delete();
    build(1'b0, 32'h00003000, 8'h00);
    send_range(0, pkt.size()-1, 2, -1);
    wait_done("t5");
    chk("t5_resp_literal", 32'(last_resp), 32'h06);
    chk("t5_err_overrun_cleared", 32'(err_overrun), 32'd0);

    // Reset in the middle of the second data word with the first write pending.
    bus.mem_ready = 1'b0;
    words.delete();
    words.push_back(32'h01020304);
    words.push_back(32'h05060708);
    build(1'b0, 32'h00004000, 8'h00);
    exp_addr.delete(); exp_data.delete(); exp_resp.delete();
    exp_runv.delete(); exp_runa.delete();
    send_range(0, 12, 2, 10);
    chk("t6_busy_before", 32'(busy), 32'd1);
    @(posedge clock); #1 reset_n = 1'b0;
    #1;
    chk("t6_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tx_valid", 32'(bus.tx_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (30) @(posedge clock); #1;
    chk("t6_no_tx_after", 32'(bus.tx_valid), 32'd0);
    chk("t6_no_write_after", 32'(bus.mem_valid), 32'd0);

`ifdef UART_LOADER_TIMEOUT_EN
    // Stall after one count byte until the idle abort fires.
    words.delete();
    build(1'b0, 32'h00005000, 8'h00);
    exp_addr.delete(); exp_data.delete(); exp_resp.delete();
    exp_runv.delete(); exp_runa.delete();
    exp_resp.push_back(NAK);
    exp_runv.push_back(1'b0);
    exp_runa.push_back(32'h0);
    send_range(0, 5, 2, -1);
    begin
      int n;
      n = 0;
      while (!bus.tx_valid && n < 300) begin
        @(posedge clock); #1;
        n++;
      end
      if (n >= 300) miss("t7_timeout_never", 32'(busy));
    end
    chk("t7_err_timeout", 32'(err_timeout), 32'd1);
    wait_done("t7");
    chk("t7_resp_literal", 32'(last_resp), 32'h15);
`else
    chk("t7_timeout_tied", 32'(err_timeout), 32'd0);
`endif

    chk("end_writes_consumed", 32'(exp_addr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got busy=%b expected completion", busy);
    $fatal(1);
  end

endmodule
